seven_seg_scanner: RTL and testbench

//  Parametrised multiplexed 7-segment display driver for the clock/stopwatch display path.
//  - Owns its own refresh timing and scans NUM_DIGITS digits in turn.
//  - Per digit it drives the anode select and the hex-decoded segment pattern, plus the decimal point.
//  - Adds a ghosting guard interval, brightness PWM, a per-digit blank mask and leading-zero blanking.
//  - Also emits a frame tick.

---
 rtl/seven_seg_scanner_pkg.sv | 16 +
 rtl/seven_seg_scanner_hex_to_seg.sv | 11 +
 rtl/seven_seg_scanner.sv | 164 ++++++++++++++++
 tb/tb_seven_seg_scanner.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_scanner_pkg.sv
// Shared constants for the multiplexed seven-segment display path:
// segment encodings and the default refresh timing for a 100 MHz clock.
package seven_seg_scanner_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // 100 MHz / 10000 cycles per slot = 10 kHz digit rate
  localparam int DEFAULT_SLOT_CYCLES = 10000;

  // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F
  localparam logic [6:0] HEX_SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seven_seg_scanner_hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment pattern decoder.
module hex_to_seg
  import seven_seg_scanner_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG_TABLE[nibble];

endmodule

// File: rtl/seven_seg_scanner.sv
// Multiplexed seven-segment scanner with anti-ghosting guard, brightness PWM,
// per-digit masking, leading-zero blanking and a frame tick.
module seven_seg_scanner
  import seven_seg_scanner_pkg::*;
#(
  parameter int NUM_DIGITS       = 4,
  parameter int SLOT_CYCLES      = DEFAULT_SLOT_CYCLES,
  parameter int GUARD_CYCLES     = 16,
  parameter int DIM_BITS         = 4,
  parameter bit ANODE_ACTIVE_LOW = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [4*NUM_DIGITS-1:0]       digit_data,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  input  logic [NUM_DIGITS-1:0]         blank_mask,
  input  logic                          lz_blank_en,
  input  logic [DIM_BITS-1:0]           brightness,
  output logic [NUM_DIGITS-1:0]         anode,
  output logic [6:0]                    seg,
  output logic                          dp,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_tick
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW = $clog2(SLOT_CYCLES);
  localparam int PW = CW + DIM_BITS + 1;

  localparam logic [CW-1:0]         LAST_CNT    = CW'(SLOT_CYCLES - 1);
  localparam logic [IW-1:0]         LAST_DIGIT  = IW'(NUM_DIGITS - 1);
  localparam logic [PW-1:0]         ACTIVE_SPAN = PW'(SLOT_CYCLES - GUARD_CYCLES);
  localparam logic [PW-1:0]         GUARD       = PW'(GUARD_CYCLES);
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF   = ANODE_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : '0;

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           digit;
  logic [4*NUM_DIGITS-1:0] snap_data;
  logic [NUM_DIGITS-1:0]   snap_dp;
  logic [NUM_DIGITS-1:0]   snap_mask;
  logic                    snap_lz;
  logic [DIM_BITS-1:0]     snap_bright;

  logic [4*NUM_DIGITS-1:0] eff_data;
  logic [NUM_DIGITS-1:0]   eff_dp;
  logic [NUM_DIGITS-1:0]   eff_mask;
  logic                    eff_lz;
  logic [DIM_BITS-1:0]     eff_bright;

  logic [NUM_DIGITS-1:0]   lz_vec;
  logic [3:0]              cur_nibble;
  logic                    cur_dp;
  logic                    cur_mask;
  logic                    cur_lz;
  logic [6:0]              dec_seg;
  logic [PW-1:0]           prod;
  logic [PW-1:0]           on_len;
  logic [PW-1:0]           cnt_w;
  logic                    in_window;
  logic [NUM_DIGITS-1:0]   onehot;
  logic [NUM_DIGITS-1:0]   anode_nxt;
  logic [6:0]              seg_nxt;
  logic                    dp_nxt;

  // The snapshot register only loads at the end of the counter==0 cycle, so
  // that cycle's outputs are computed from the live inputs instead.
  always_comb begin
    eff_data   = snap_data;
    eff_dp     = snap_dp;
    eff_mask   = snap_mask;
    eff_lz     = snap_lz;
    eff_bright = snap_bright;
    if (cnt == '0) begin
      eff_data   = digit_data;
      eff_dp     = dp_in;
      eff_mask   = blank_mask;
      eff_lz     = lz_blank_en;
      eff_bright = brightness;
    end
  end

  always_comb begin
    logic upper_zero;
    upper_zero = 1'b1;
    lz_vec     = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      upper_zero = upper_zero && (eff_data[4*k +: 4] == 4'h0);
      lz_vec[k]  = eff_lz && upper_zero && (k > 0);
    end
  end

  always_comb begin
    cur_nibble = '0;
    cur_dp     = 1'b0;
    cur_mask   = 1'b0;
    cur_lz     = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (IW'(k) == digit) begin
        cur_nibble = eff_data[4*k +: 4];
        cur_dp     = eff_dp[k];
        cur_mask   = eff_mask[k];
        cur_lz     = lz_vec[k];
      end
    end
  end

  hex_to_seg u_hex_to_seg (
    .nibble (cur_nibble),
    .seg    (dec_seg)
  );

  // Full brightness bypasses the shift so the anode covers the whole post-guard slot.
  always_comb begin
    prod      = ACTIVE_SPAN * PW'(eff_bright);
    on_len    = (eff_bright == '1) ? ACTIVE_SPAN : (prod >> DIM_BITS);
    cnt_w     = PW'(cnt);
    in_window = (cnt_w >= GUARD) && (cnt_w < GUARD + on_len);
    onehot    = NUM_DIGITS'(1) << digit;

    anode_nxt = ANODE_OFF;
    if (!cur_mask && !cur_lz && (eff_bright != '0) && in_window) begin
      anode_nxt = ANODE_ACTIVE_LOW ? ~onehot : onehot;
    end
    seg_nxt = (cur_mask || cur_lz) ? SEG_OFF : dec_seg;
    dp_nxt  = cur_mask ? 1'b1 : ~cur_dp;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      digit       <= '0;
      snap_data   <= '0;
      snap_dp     <= '0;
      snap_mask   <= '0;
      snap_lz     <= 1'b0;
      snap_bright <= '0;
      anode       <= ANODE_OFF;
      seg         <= SEG_OFF;
      dp          <= 1'b1;
      frame_tick  <= 1'b0;
    end else begin
      if (cnt == LAST_CNT) begin
        cnt   <= '0;
        digit <= (digit == LAST_DIGIT) ? '0 : digit + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (cnt == '0) begin
        snap_data   <= digit_data;
        snap_dp     <= dp_in;
        snap_mask   <= blank_mask;
        snap_lz     <= lz_blank_en;
        snap_bright <= brightness;
      end
      anode      <= anode_nxt;
      seg        <= seg_nxt;
      dp         <= dp_nxt;
      frame_tick <= (cnt == LAST_CNT) && (digit == LAST_DIGIT);
    end
  end

  assign digit_idx = digit;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner: per-cycle reference model, a
// vector table of whole-frame expectations, and hand-written corner sequences.
module tb_seven_seg_scanner;

  localparam int SLOT  = 32;
  localparam int FRAME = 128;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  mask;
    logic        lz;
    logic [1:0]  bright;
  } in_t;

  typedef struct {
    in_t         stim;
    logic [27:0] seg_exp;
    logic [3:0]  dp_exp;
    logic [3:0]  lit;
    int          on_len;
  } vec_t;

  localparam logic [6:0] SEG_REF [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] digit_data = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_mask = '0;
  logic        lz_blank_en = 1'b0;
  logic [1:0]  brightness = '0;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        dp;
  logic [1:0]  digit_idx;
  logic        frame_tick;

  int  n_checks = 0;
  int  n_fails  = 0;
  int  n        = 0;
  in_t hist[$];
  in_t cur;
  vec_t vecs [10];

  seven_seg_scanner #(
    .NUM_DIGITS       (4),
    .SLOT_CYCLES      (SLOT),
    .GUARD_CYCLES     (4),
    .DIM_BITS         (2),
    .ANODE_ACTIVE_LOW (1'b1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .digit_data  (digit_data),
    .dp_in       (dp_in),
    .blank_mask  (blank_mask),
    .lz_blank_en (lz_blank_en),
    .brightness  (brightness),
    .anode       (anode),
    .seg         (seg),
    .dp          (dp),
    .digit_idx   (digit_idx),
    .frame_tick  (frame_tick)
  );

  always #5 clk = ~clk;

  // Expected {anode, seg, dp, digit_idx, frame_tick} in cycle n after reset release
  function automatic logic [14:0] model_out(int cyc);
    in_t s;
    int m, c, d, slot, on_len;
    logic lzb;
    logic [3:0] an;
    logic [6:0] sg;
    logic dpv;
    if (cyc == 0) return {4'hF, 7'h7F, 1'b1, 2'd0, 1'b0};
    m    = cyc - 1;
    c    = m % SLOT;
    slot = m / SLOT;
    d    = slot % 4;
    s    = hist[slot * SLOT];
    lzb  = 1'b0;
    if (s.lz && d > 0) begin
      lzb = 1'b1;
      for (int j = d; j < 4; j++) if (s.data[4*j +: 4] != 4'h0) lzb = 1'b0;
    end
    on_len = (s.bright == 2'd3) ? 28 : (28 * int'(s.bright)) / 4;
    an = 4'hF;
    if (!s.mask[d] && !lzb && s.bright != 0 && c >= 4 && c < 4 + on_len) an[d] = 1'b0;
    sg  = (s.mask[d] || lzb) ? 7'h7F : SEG_REF[s.data[4*d +: 4]];
    dpv = s.mask[d] ? 1'b1 : ~s.dp[d];
    return {an, sg, dpv, 2'((cyc / SLOT) % 4), (cyc % FRAME == 0)};
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s (cycle %0d): got %h expected %h", name, n, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input in_t v);
    digit_data  = v.data;
    dp_in       = v.dp;
    blank_mask  = v.mask;
    lz_blank_en = v.lz;
    brightness  = v.bright;
  endtask

  task automatic step(input in_t v);
    @(posedge clk);
    #1;
    n++;
    check_output("cycle_outputs", 32'({anode, seg, dp, digit_idx, frame_tick}), 32'(model_out(n)));
    apply_stimulus(v);
    hist.push_back(v);
  endtask

  task automatic do_reset(input in_t v);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_output("reset_state", 32'({anode, seg, dp, digit_idx, frame_tick}), 32'({4'hF, 7'h7F, 1'b1, 2'd0, 1'b0}));
    reset = 1'b0;
    n = 0;
    hist.delete();
    apply_stimulus(v);
    hist.push_back(v);
  endtask

  initial begin
    int on_cnt [4];
    int ticks, m, c, d;
    in_t nxt;

    vecs[0] = '{'{16'h1234, 4'h0, 4'h0, 1'b0, 2'd3}, {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF, 4'hF, 28};
    vecs[1] = '{'{16'h1234, 4'h0, 4'h0, 1'b0, 2'd2}, {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF, 4'hF, 14};
    vecs[2] = '{'{16'h1234, 4'h0, 4'h0, 1'b0, 2'd0}, {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF, 4'h0, 0};
    vecs[3] = '{'{16'h0005, 4'h0, 4'h0, 1'b1, 2'd3}, {7'h7F, 7'h7F, 7'h7F, 7'h12}, 4'hF, 4'h1, 28};
    vecs[4] = '{'{16'h0000, 4'h0, 4'h0, 1'b1, 2'd3}, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF, 4'h1, 28};
    vecs[5] = '{'{16'h0000, 4'h0, 4'h0, 1'b0, 2'd3}, {7'h40, 7'h40, 7'h40, 7'h40}, 4'hF, 4'hF, 28};
    vecs[6] = '{'{16'h89AB, 4'b0010, 4'b0100, 1'b0, 2'd3}, {7'h00, 7'h7F, 7'h08, 7'h03}, 4'b1101, 4'b1011, 28};
    vecs[7] = '{'{16'h0070, 4'b1000, 4'b0001, 1'b1, 2'd1}, {7'h7F, 7'h7F, 7'h78, 7'h7F}, 4'b0111, 4'b0010, 7};
    vecs[8] = '{'{16'hCDEF, 4'h0, 4'h0, 1'b0, 2'd3}, {7'h46, 7'h21, 7'h06, 7'h0E}, 4'hF, 4'hF, 28};
    vecs[9] = '{'{16'h5690, 4'h0, 4'h0, 1'b1, 2'd2}, {7'h12, 7'h02, 7'h10, 7'h40}, 4'hF, 4'hF, 14};

    $display("[TB] starting seven_seg_scanner bench");
    cur = vecs[0].stim;
    repeat (2) @(posedge clk);
    #1;
    do_reset(cur);

    // Frame-level table: each vector held until a whole frame is observed from fresh snapshots
    for (int i = 0; i < 10; i++) begin
      cur = vecs[i].stim;
      step(cur);
      while (n % FRAME != 0) step(cur);
      on_cnt = '{default: 0};
      for (int k = 0; k < FRAME; k++) begin
        step(cur);
        m = n - 1;
        c = m % SLOT;
        d = (m / SLOT) % 4;
        if (anode[d] == 1'b0) on_cnt[d]++;
        if (c == 16) begin
          check_output("vec_seg", 32'(seg), 32'(vecs[i].seg_exp[7*d +: 7]));
          check_output("vec_dp", 32'(dp), 32'(vecs[i].dp_exp[d]));
        end
      end
      for (int k = 0; k < 4; k++)
        check_output("vec_on_len", 32'(on_cnt[k]), vecs[i].lit[k] ? 32'(vecs[i].on_len) : 32'd0);
    end

    // Exactly one frame tick per 128 cycles
    cur = vecs[0].stim;
    ticks = 0;
    for (int k = 0; k < 4 * FRAME; k++) begin
      step(cur);
      if (frame_tick) ticks++;
    end
    check_output("frame_tick_count", 32'(ticks), 32'd4);

    // Mid-slot data change must not tear digit 0's slot
    while (n % FRAME != 9) step(cur);
    nxt = cur;
    nxt.data = 16'h5678;
    cur = nxt;
    step(cur);
    while (n % FRAME != 32) step(cur);
    check_output("snap_hold", 32'(seg), 32'h19);
    step(cur);
    check_output("snap_next_slot", 32'(seg), 32'h78);
    while (n % FRAME != 6) step(cur);
    check_output("snap_new_d0", 32'(seg), 32'h00);

    // Reset at counter 20 of digit 2, then full guard on restart
    cur = vecs[0].stim;
    while (n % FRAME != 84) step(cur);
    do_reset(cur);
    for (int k = 1; k <= 5; k++) begin
      step(cur);
      check_output(k < 5 ? "post_reset_guard" : "post_reset_enable", 32'(anode), k < 5 ? 32'hF : 32'hE);
    end

    // Randomised inputs against the reference model
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 15) == 0) begin
        for (int j = 0; j < 4; j++)
          cur.data[4*j +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        cur.dp     = 4'($urandom_range(0, 15));
        cur.mask   = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
        cur.lz     = 1'($urandom_range(0, 1));
        cur.bright = 2'($urandom_range(0, 3));
      end
      step(cur);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
